// File: rtl/regfile_2r1w_bypass.sv
`default_nettype none
// ============================================================================
// Module   : regfile_2r1w_bypass
// Brief    : 2-read/1-write register file with write-to-read bypass,
//            registered stall-held reads, optional zero register and
//            post-reset init sweep (entry i <= i).
// Revision : 1.0
// ============================================================================
module regfile_2r1w_bypass #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int INIT_EN  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] IF_ID_Rs,
  input  logic [ADDR_W-1:0] IF_ID_Rt,
  input  logic              Stall,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WB_DstReg,
  input  logic [DATA_W-1:0] WB_Data,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic              Ready
);

  localparam int C_DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] C_LAST = ADDR_W'(C_DEPTH - 1);

  typedef enum logic [0:0] {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   init_ptr_q, init_ptr_d;
  logic [DATA_W-1:0]   rd1_q, rd1_d;
  logic [DATA_W-1:0]   rd2_q, rd2_d;
  logic [DATA_W-1:0]   mem_q [C_DEPTH];

  logic                w_we;
  logic [ADDR_W-1:0]   w_waddr;
  logic [DATA_W-1:0]   w_wdata;
  logic                w_run_we;
  logic [DATA_W-1:0]   w_rd1_val;
  logic [DATA_W-1:0]   w_rd2_val;

  // A RUN write to entry 0 is dropped entirely when it is hardwired to zero.
  assign w_run_we = RegWrite && !((ZERO_REG != 0) && (WB_DstReg == '0));

  always_comb begin
    w_rd1_val = mem_q[IF_ID_Rs];
    if ((ZERO_REG != 0) && (IF_ID_Rs == '0))
      w_rd1_val = '0;
    else if (w_run_we && (WB_DstReg == IF_ID_Rs))
      w_rd1_val = WB_Data;

    w_rd2_val = mem_q[IF_ID_Rt];
    if ((ZERO_REG != 0) && (IF_ID_Rt == '0))
      w_rd2_val = '0;
    else if (w_run_we && (WB_DstReg == IF_ID_Rt))
      w_rd2_val = WB_Data;
  end

  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    rd1_d      = rd1_q;
    rd2_d      = rd2_q;
    w_we       = 1'b0;
    w_waddr    = WB_DstReg;
    w_wdata    = WB_Data;
    case (state_q)
      S_INIT: begin
        if (INIT_EN != 0) begin
          w_we       = 1'b1;
          w_waddr    = init_ptr_q;
          w_wdata    = DATA_W'(init_ptr_q);
          init_ptr_d = init_ptr_q + 1'b1;
          if (init_ptr_q == C_LAST)
            state_d = S_RUN;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        w_we = w_run_we;
        if (!Stall) begin
          rd1_d = w_rd1_val;
          rd2_d = w_rd2_val;
        end
      end
      default: state_d = S_INIT;
    endcase
    // No array write may land on an edge that sees reset asserted.
    if (rst)
      w_we = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_INIT;
      init_ptr_q <= '0;
      rd1_q      <= '0;
      rd2_q      <= '0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
      rd1_q      <= rd1_d;
      rd2_q      <= rd2_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_we)
      mem_q[w_waddr] <= w_wdata;
  end

  assign ReadData1 = rd1_q;
  assign ReadData2 = rd2_q;
  assign Ready     = (state_q == S_RUN);

endmodule
`default_nettype wire
